// File: rtl/spi_sensor_responder.sv
// SPI mode-3 responder exposing a 64x8 register file with a read-only WHOAMI byte at 0x0F.
// Define SPI_AUTOINC_EN to honour the MS bit (address auto-increment); otherwise every data byte targets the start address.
module spi_sensor_responder #(
    parameter logic [7:0] WHOAMI      = 8'h33,
    parameter int         SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic       spi_sck,
    input  logic       spi_csn,
    input  logic       spi_mosi,
    output logic       spi_miso,
    output logic       spi_miso_oe,
    input  logic       ld_we,
    input  logic [5:0] ld_addr,
    input  logic [7:0] ld_data,
    output logic       wr_stb,
    output logic [5:0] wr_addr,
    output logic [7:0] wr_data,
    output logic       busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_CMD     = 2'd1;
    localparam logic [1:0] ST_DATA    = 2'd2;
    localparam logic [1:0] ST_WAIT_CS = 2'd3;

    localparam logic [5:0] WHOAMI_ADDR = 6'h0F;
    localparam logic [2:0] SETTLE_MAX  = 3'(SYNC_STAGES);

`ifdef SPI_AUTOINC_EN
    localparam logic AUTOINC = 1'b1;
`else
    localparam logic AUTOINC = 1'b0;
`endif

    // Pin synchronizers preset to the bus idle levels so reset never fabricates an edge.
    logic [SYNC_STAGES-1:0] sck_sync, csn_sync, mosi_sync;
    logic                   sck_d, csn_d;
    logic                   sck_s, csn_s, mosi_s;
    logic                   sck_rise, sck_fall, csn_rise, csn_fall, sample;

    always_ff @(posedge clk) begin
        if (!resetn) begin
            sck_sync  <= '1;
            csn_sync  <= '1;
            mosi_sync <= '0;
            sck_d     <= 1'b1;
            csn_d     <= 1'b1;
        end else begin
            sck_sync  <= {sck_sync[SYNC_STAGES-2:0], spi_sck};
            csn_sync  <= {csn_sync[SYNC_STAGES-2:0], spi_csn};
            mosi_sync <= {mosi_sync[SYNC_STAGES-2:0], spi_mosi};
            sck_d     <= sck_s;
            csn_d     <= csn_s;
        end
    end

    assign sck_s    = sck_sync[SYNC_STAGES-1];
    assign csn_s    = csn_sync[SYNC_STAGES-1];
    assign mosi_s   = mosi_sync[SYNC_STAGES-1];
    assign sck_rise = sck_s & ~sck_d;
    assign sck_fall = ~sck_s & sck_d;
    assign csn_rise = csn_s & ~csn_d;
    assign csn_fall = ~csn_s & csn_d;
    assign sample   = sck_rise & ~csn_s;

    logic [1:0] state;
    logic [2:0] bit_cnt;
    logic [2:0] settle;
    logic [6:0] shift;
    logic       rw;
    logic       inc_en;
    logic [5:0] addr;
    logic [7:0] rd_byte;
    logic       miso_q, oe_q, busy_q;
    logic       wr_stb_q;
    logic [5:0] wr_addr_q;
    logic [7:0] wr_data_q;

    logic [7:0] mem [64];

    logic [7:0] rx_byte;
    logic       byte_done;
    logic       spi_we;
    logic [5:0] next_addr;
    logic [5:0] rd_addr;
    logic [7:0] rd_data;

    always_comb begin
        rx_byte   = {shift, mosi_s};
        byte_done = sample && (bit_cnt == 3'd7);
        spi_we    = (state == ST_DATA) && !rw && byte_done;
        next_addr = inc_en ? addr + 6'd1 : addr;
        // Byte about to start: the command's target, or the advanced data address.
        rd_addr   = (state == ST_CMD) ? rx_byte[5:0] : next_addr;
        rd_data   = (rd_addr == WHOAMI_ADDR) ? WHOAMI : mem[rd_addr];
    end

    // SPI commit has priority; a colliding local preload is simply dropped.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            for (int i = 0; i < 64; i++) mem[i] <= '0;
        end else if (spi_we) begin
            if (addr != WHOAMI_ADDR) mem[addr] <= rx_byte;
        end else if (ld_we && ld_addr != WHOAMI_ADDR) begin
            mem[ld_addr] <= ld_data;
        end
    end

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state     <= ST_WAIT_CS;
            bit_cnt   <= '0;
            settle    <= '0;
            shift     <= '0;
            rw        <= 1'b0;
            inc_en    <= 1'b0;
            addr      <= '0;
            rd_byte   <= '0;
            miso_q    <= 1'b0;
            oe_q      <= 1'b0;
            busy_q    <= 1'b0;
            wr_stb_q  <= 1'b0;
            wr_addr_q <= '0;
            wr_data_q <= '0;
        end else begin
            wr_stb_q <= 1'b0;
            if (csn_rise) begin
                state   <= ST_IDLE;
                busy_q  <= 1'b0;
                oe_q    <= 1'b0;
                miso_q  <= 1'b0;
                bit_cnt <= '0;
                settle  <= '0;
            end else begin
                case (state)
                    // Demand SYNC_STAGES+1 high samples so the preset values have flushed.
                    ST_WAIT_CS: begin
                        if (csn_s) begin
                            if (settle == SETTLE_MAX) state <= ST_IDLE;
                            else                      settle <= settle + 3'd1;
                        end else begin
                            settle <= '0;
                        end
                    end
                    ST_IDLE: begin
                        if (csn_fall) begin
                            state   <= ST_CMD;
                            bit_cnt <= '0;
                            busy_q  <= 1'b1;
                        end
                    end
                    ST_CMD: begin
                        if (sample) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                rw      <= rx_byte[7];
                                inc_en  <= AUTOINC & rx_byte[6];
                                addr    <= rx_byte[5:0];
                                rd_byte <= rd_data;
                                state   <= ST_DATA;
                            end
                        end
                    end
                    ST_DATA: begin
                        if (sample) begin
                            shift   <= rx_byte[6:0];
                            bit_cnt <= bit_cnt + 3'd1;
                            if (byte_done) begin
                                addr    <= next_addr;
                                rd_byte <= rd_data;
                                if (!rw) begin
                                    wr_stb_q  <= 1'b1;
                                    wr_addr_q <= addr;
                                    wr_data_q <= rx_byte;
                                end
                            end
                        end else if (sck_fall && rw) begin
                            miso_q  <= rd_byte[7];
                            rd_byte <= {rd_byte[6:0], 1'b0};
                            oe_q    <= 1'b1;
                        end
                    end
                    default: state <= ST_WAIT_CS;
                endcase
            end
        end
    end

    assign spi_miso    = miso_q & oe_q;
    assign spi_miso_oe = oe_q;
    assign busy        = busy_q;
    assign wr_stb      = wr_stb_q;
    assign wr_addr     = wr_addr_q;
    assign wr_data     = wr_data_q;

endmodule
